vape_multi_or_monitor: RTL

//  Registered, parametrised output-region (OR) integrity monitor for executable-region (ER) attestation.

---
 rtl/vape_multi_or_monitor.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/vape_multi_or_monitor.sv
// vape_multi_or_monitor
// Watches the PC and the CPU/DMA write strobes against NUM_OR output-region
// windows. It keeps exec high only while an executable-region run is unbroken.
// It also keeps sticky per-window violation flags, a saturating count of
// violating cycles, and a DONE state that marks a legitimate exit from the ER.
module vape_multi_or_monitor #(
   parameter int                 ADDR_W            = 16,
   parameter int                 NUM_OR            = 2,
   parameter int                 CNT_W             = 8,
   parameter logic [ADDR_W-1:0]  RESET_HANDLER     = '0,
   parameter bit                 DMA_IN_ER_ALLOWED = 1'b0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [ADDR_W-1:0]        pc,
   input  logic [ADDR_W-1:0]        data_addr,
   input  logic                     data_en,
   input  logic [ADDR_W-1:0]        dma_addr,
   input  logic                     dma_en,
   input  logic [ADDR_W-1:0]        ER_min,
   input  logic [ADDR_W-1:0]        ER_max,
   input  logic [NUM_OR-1:0]        OR_en,
   input  logic [NUM_OR*ADDR_W-1:0] OR_min,
   input  logic [NUM_OR*ADDR_W-1:0] OR_max,
   output logic                     exec,
   output logic [1:0]               state_o,
   output logic [NUM_OR-1:0]        viol_mask,
   output logic [CNT_W-1:0]         viol_cnt
);

   typedef enum logic [1:0] {
      ST_ABORT = 2'b00,
      ST_RUN   = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   prev_pc_q;
   logic [NUM_OR-1:0]   mask_q, mask_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic [NUM_OR-1:0]   hit_cpu, hit_dma, win_bad, viol_bits;
   logic                in_er, cfg_bad, vio_cpu, vio_dma, vio, new_run;

   // Per-window address decode; disabled windows never hit and never count as misconfigured.
   for (genvar g = 0; g < NUM_OR; g++) begin : g_win
      logic [ADDR_W-1:0] lo, hi;
      assign lo         = OR_min[g*ADDR_W +: ADDR_W];
      assign hi         = OR_max[g*ADDR_W +: ADDR_W];
      assign hit_cpu[g] = data_en & OR_en[g] & (data_addr >= lo) & (data_addr <= hi);
      assign hit_dma[g] = dma_en  & OR_en[g] & (dma_addr  >= lo) & (dma_addr  <= hi);
      assign win_bad[g] = OR_en[g] & ~(lo < hi);
   end

   assign in_er   = (pc >= ER_min) & (pc <= ER_max);
   assign cfg_bad = ~(ER_min < ER_max) | (|win_bad);
   assign vio_cpu = (|hit_cpu) & ~in_er;
   assign vio_dma = (|hit_dma) & (DMA_IN_ER_ALLOWED ? ~in_er : 1'b1);
   assign vio     = vio_cpu | vio_dma;

   // Only the sources that actually violated contribute their hit bits.
   assign viol_bits = ({NUM_OR{vio_cpu}} & hit_cpu) | ({NUM_OR{vio_dma}} & hit_dma);

   // State register; reset drops straight to ABORT without waiting for a clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_ABORT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state rules in priority order; new_run flags an entry into a fresh run.
   always_comb begin
      state_d = state_q;
      new_run = 1'b0;
      if ((pc == RESET_HANDLER) || cfg_bad) begin
         state_d = ST_ABORT;
      end else if (vio) begin
         state_d = ST_ABORT;
      end else begin
         case (state_q)
            ST_ABORT: begin
               if (pc == ER_min) begin
                  state_d = ST_RUN;
                  new_run = 1'b1;
               end
            end
            ST_RUN: begin
               if (!in_er) begin
                  state_d = (prev_pc_q == ER_max) ? ST_DONE : ST_ABORT;
               end
            end
            ST_DONE: begin
               if (pc == ER_min) begin
                  state_d = ST_RUN;
                  new_run = 1'b1;
               end else if (in_er) begin
                  state_d = ST_ABORT;
               end
            end
            default: state_d = ST_ABORT;
         endcase
      end
   end

   // Outputs decode directly from the registered state, so exec moves on the same edge as state.
   always_comb begin
      exec    = (state_q == ST_RUN) || (state_q == ST_DONE);
      state_o = state_q;
   end

   // Sticky mask: a violation always sets bits; a clean new run clears the history.
   always_comb begin
      mask_d = mask_q;
      if (vio) begin
         mask_d = mask_q | viol_bits;
      end else if (new_run) begin
         mask_d = '0;
      end
   end

   // Violation counter saturates at all-ones rather than wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (vio && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Previous PC, violation mask and counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_pc_q <= '0;
         mask_q    <= '0;
         cnt_q     <= '0;
      end else begin
         prev_pc_q <= pc;
         mask_q    <= mask_d;
         cnt_q     <= cnt_d;
      end
   end

   assign viol_mask = mask_q;
   assign viol_cnt  = cnt_q;

endmodule
